// File: rtl/dot_matrix_pkg.sv
// Shared geometry, types and FSM encoding for the 5x7 dot-matrix scan driver.
package dot_matrix_pkg;

  localparam int N_COLS = 5;
  localparam int N_ROWS = 7;
  localparam logic [4:0] COL_IDLE = 5'b11111;

  typedef logic [2:0] col_idx_t;
  typedef logic [6:0] row_bits_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } scan_state_t;

  // One-cold strobe pattern with the selected column pulled low.
  function automatic logic [4:0] col_strobe(input col_idx_t col);
    col_strobe = ~(5'b00001 << col);
  endfunction

endpackage

// File: rtl/dot_matrix_scanner_scan_timer.sv
// Dwell counter and column index for the matrix scan; flags the blanking
// window at the start of each dwell and the last cycle of every frame.
module scan_timer
  import dot_matrix_pkg::*;
#(
  parameter int SCAN_DIV  = 300000,
  parameter int BLANK_CYC = 1000
) (
  input  logic     clk,
  input  logic     rst,
  output col_idx_t col_idx,
  output logic     blank,
  output logic     frame_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_r;
  col_idx_t         col_r;
  logic             dwell_end_s;

  assign dwell_end_s = (cnt_r == CNT_W'(SCAN_DIV - 1));
  assign col_idx     = col_r;
  assign blank       = (cnt_r < CNT_W'(BLANK_CYC));
  assign frame_end   = dwell_end_s && (col_r == 3'(N_COLS - 1));

  // Dwell counter wraps every SCAN_DIV cycles and steps the column 0..4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      col_r <= 3'd0;
    end else if (dwell_end_s) begin
      cnt_r <= '0;
      col_r <= (col_r == 3'(N_COLS - 1)) ? 3'd0 : col_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      col_r <= col_r;
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Double-buffered 5x7 LED matrix scanner: back buffer is written through a
// valid/ready port and published to the displayed front buffer at frame end.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int SCAN_DIV  = 300000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_col,
  input  logic [6:0] wr_data,
  input  logic       frame_commit,
  output logic       swap_ack,
  output logic [6:0] a,
  output logic [4:0] colomn
);

  row_bits_t [N_COLS-1:0] back_r;
  row_bits_t [N_COLS-1:0] front_r;
  row_bits_t [N_COLS-1:0] back_next_s;
  scan_state_t            state_r;
  scan_state_t            state_next_s;
  logic                   wr_ready_r;
  logic                   swap_ack_r;
  row_bits_t              a_r;
  logic [4:0]             colomn_r;

  col_idx_t               col_idx_s;
  logic                   blank_s;
  logic                   frame_end_s;
  logic                   wr_acc_s;
  logic                   commit_acc_s;
  logic                   swap_s;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .col_idx   (col_idx_s),
    .blank     (blank_s),
    .frame_end (frame_end_s)
  );

  assign wr_acc_s     = wr_valid && wr_ready_r;
  assign commit_acc_s = frame_commit && wr_ready_r;
  // A commit sampled on the boundary cycle publishes immediately.
  assign swap_s       = frame_end_s && ((state_r == PENDING) || commit_acc_s);

  // Next back-buffer contents; out-of-range columns are accepted and dropped.
  always_comb begin
    back_next_s = back_r;
    if (wr_acc_s && (wr_col < 3'(N_COLS))) begin
      back_next_s[wr_col] = wr_data;
    end else begin
      back_next_s = back_r;
    end
  end

  // Commit FSM: IDLE accepts traffic, PENDING stalls until the frame boundary.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = (commit_acc_s && !swap_s) ? PENDING : IDLE;
      PENDING: state_next_s = swap_s ? IDLE : PENDING;
      default: state_next_s = IDLE;
    endcase
  end

  // Buffers, FSM and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      back_r     <= '0;
      front_r    <= '0;
      state_r    <= IDLE;
      wr_ready_r <= 1'b1;
      swap_ack_r <= 1'b0;
    end else begin
      back_r     <= back_next_s;
      front_r    <= swap_s ? back_next_s : front_r;
      state_r    <= state_next_s;
      // Ready stays low through the swap_ack cycle and returns one cycle later.
      wr_ready_r <= (state_r == IDLE) && !commit_acc_s && !swap_s;
      swap_ack_r <= swap_s;
    end
  end

  // Registered matrix drive, blanked at the start of every dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= 7'd0;
      colomn_r <= COL_IDLE;
    end else if (blank_s) begin
      a_r      <= 7'd0;
      colomn_r <= COL_IDLE;
    end else begin
      a_r      <= front_r[col_idx_s];
      colomn_r <= col_strobe(col_idx_s);
    end
  end

  assign wr_ready = wr_ready_r;
  assign swap_ack = swap_ack_r;
  assign a        = a_r;
  assign colomn   = colomn_r;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Randomized bench for dot_matrix_scanner against a frame-position reference model.
module tb_dot_matrix_scanner;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int NC    = 5;
  localparam int FRAME = SD * NC;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_col;
  logic [6:0] wr_data;
  logic       frame_commit;
  logic       swap_ack;
  logic [6:0] a;
  logic [4:0] colomn;

  always #5 clk = ~clk;

  dot_matrix_scanner #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .frame_commit (frame_commit),
    .swap_ack     (swap_ack),
    .a            (a),
    .colomn       (colomn)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_swaps = 0;

  // Reference state: buffers, cycles since reset release, pending commit.
  logic [6:0] m_back [NC];
  logic [6:0] m_front[NC];
  int         k;
  bit         m_pend;
  bit         m_ready;
  bit         acc_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_back[i]  = 7'd0;
      m_front[i] = 7'd0;
    end
    k        = 0;
    m_pend   = 1'b0;
    m_ready  = 1'b1;
    acc_last = 1'b0;
  endtask

  // Advance one clock: predict from the frame position, then compare outputs.
  task automatic step();
    int         col;
    int         cnt;
    bit         bnd;
    bit         cacc;
    bit         swap;
    logic [6:0] nb[NC];
    logic [6:0] exp_a;
    logic [4:0] exp_col;
    acc_last = m_ready && wr_valid;
    cacc     = m_ready && frame_commit;
    nb       = m_back;
    if (acc_last && wr_col < 3'd5) nb[int'(wr_col)] = wr_data;
    col  = (k / SD) % NC;
    cnt  = k % SD;
    bnd  = (k % FRAME) == FRAME - 1;
    exp_a   = (cnt < BC) ? 7'd0 : m_front[col];
    exp_col = (cnt < BC) ? 5'h1f : (5'h1f ^ (5'd1 << col));
    swap = bnd && (m_pend || cacc);
    if (swap) begin
      m_front = nb;
      m_pend  = 1'b0;
    end else if (cacc) begin
      m_pend = 1'b1;
    end
    m_back  = nb;
    m_ready = !m_pend && !swap;
    k++;
    @(posedge clk);
    #1;
    check_eq("a", 32'(a), 32'(exp_a));
    check_eq("colomn", 32'(colomn), 32'(exp_col));
    check_eq("swap_ack", 32'(swap_ack), 32'(swap));
    check_eq("wr_ready", 32'(wr_ready), 32'(m_ready));
    if (swap_ack) n_swaps++;
  endtask

  // Hold a stalled write; otherwise draw a fresh request.
  task automatic drive_random(input int pw, input int pc);
    if (!(wr_valid && !acc_last)) begin
      wr_valid = ($urandom_range(99) < pw);
      wr_col   = 3'($urandom_range(7));
      wr_data  = 7'($urandom);
    end
    frame_commit = ($urandom_range(99) < pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a"}, 32'(a), 32'd0);
    check_eq({tag, "_colomn"}, 32'(colomn), 32'h1f);
    check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check_eq({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    wr_valid     = 1'b0;
    wr_col       = 3'd0;
    wr_data      = 7'd0;
    frame_commit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Writes without any commit: nothing may be published or lit.
    for (int i = 0; i < 3 * FRAME; i++) begin
      drive_random(70, 0);
      frame_commit = 1'b0;
      step();
    end
    check_eq("no_swap", 32'(n_swaps), 32'd0);

    // Same-cycle write of column 0 and commit.
    wr_valid = 1'b0;
    for (int i = 0; i < FRAME && !m_ready; i++) step();
    wr_valid     = 1'b1;
    wr_col       = 3'd0;
    wr_data      = 7'b0000001;
    frame_commit = 1'b1;
    step();
    wr_valid     = 1'b0;
    frame_commit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) step();

    for (int i = 0; i < 1200; i++) begin
      drive_random(60, 4);
      step();
    end

    // Asynchronous reset in the middle of column 3's dwell.
    for (int i = 0; i < FRAME && (k % FRAME) != 3 * SD + 4; i++) begin
      drive_random(50, 3);
      step();
    end
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    wr_valid     = 1'b0;
    frame_commit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 800; i++) begin
      drive_random(60, 8);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scanner.md
# dot_matrix_scanner

Frame-buffered scan driver for the 5-column × 7-row LED dot matrix. The game logic writes the next frame column by column through a valid/ready write port. The game then commits the frame. The block swaps the frame in only at a scan-frame boundary, so no tearing is visible. It multiplexes the active frame onto the active-low column strobes and the row data lines, and replaces the ad-hoc scan loop that currently lives inside the game logic.

## Interface
Parameters:
- SCAN_DIV, 300000: clk cycles per column dwell; ≥ 4.
- BLANK_CYC, 1000: cycles at the start of each dwell with the display blanked (anti-ghosting); ≥ 1, < SCAN_DIV.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: write/commit accept.
- wr_col, in, 3: target column, 0–4 valid.
- wr_data, in, 7: row bits for that column; bit n lights row n.
- frame_commit, in, 1: request to publish the back buffer.
- swap_ack, out, 1: one-cycle pulse when the front buffer is loaded.
- a, out, 7: row data to the matrix, active-high.
- colomn, out, 5: column strobes; active-low, one-cold.

## Operation
- Two buffers of 5 × 7 bits each: back (written by the port) and front (displayed).
- Write handshake: a write is accepted on a cycle with wr_valid && wr_ready.
  - back[wr_col] <= wr_data.
  - wr_col 5–7 is accepted and dropped, with no buffer change.
- Commit handshake: frame_commit is sampled when wr_ready=1. On a sampled commit, the FSM goes IDLE → PENDING.
  - In PENDING, wr_ready=0 and further writes and commits stall. Held wr_valid/wr_data must remain valid, and nothing is lost.
  - At the frame boundary, front <= back and swap_ack=1 for that cycle, and the FSM returns to IDLE.
  - The back buffer is kept, so incremental updates do not need a full rewrite.
- Simultaneous write and commit in the same accepted cycle: the write lands in back first and is included in the published frame.
- A commit sampled in the same cycle as a frame boundary publishes at that boundary.
- Scan sequencing:
  - A dwell counter runs 0..SCAN_DIV-1.
  - A column index runs 0..4, advancing on dwell wrap and wrapping 4 → 0.
  - The frame boundary is the cycle where column 4's dwell counter equals SCAN_DIV-1.
- Display during a dwell:
  - Counter < BLANK_CYC: colomn=5'b11111, a=0.
  - Otherwise: colomn has bit[col] = 0 and all other bits 1, and a = front[col].
- Reset (asynchronous):
  - Both buffers cleared, FSM to IDLE.
  - Counter = 0, column index = 0.
  - a=0, colomn=5'b11111, wr_ready=1, swap_ack=0.
  - A reset in PENDING discards the pending commit.

## Timing
- a and colomn are registered and lag the internal counter/column state by 1 cycle.
- A written column becomes visible no earlier than the boundary following its commit. The first lit cycle for column c is boundary + 1 + c·SCAN_DIV + BLANK_CYC + 1.
- Commit-to-swap latency is 0 to 5·SCAN_DIV−1 cycles.
- wr_ready rises the cycle after swap_ack.
- swap_ack is asserted for exactly one cycle per swap and never twice within one frame.
- Refresh at the defaults on a 50 MHz clk: 6 ms per column, 30 ms per frame.

## Structure
- Package dot_matrix_pkg holds:
  - N_COLS=5, N_ROWS=7.
  - COL_IDLE=5'b11111.
  - typedef col_idx_t (3 bits), row_bits_t (7 bits).
  - FSM state enum {IDLE, PENDING}.
- Sub-module scan_timer (dwell counter and column index) outputs col_idx, blank and frame_end. Buffers, FSM and output registers stay in dot_matrix_scanner.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2.
1. Assert rst mid-dwell in column 3 → on the same edge, a=0, colomn=11111, wr_ready=1. After release, the scan restarts at column 0.
2. Write col 2 = 7'b0010000, then commit during column 0 → swap_ack pulses at the column-4 end. In the next frame, colomn=11011 with a=0010000 for 6 cycles, after 2 blank cycles.
3. Commit, then hold wr_valid with col 1 = 7'b1111111 → wr_ready=0 until swap_ack. The write is accepted the cycle after, is absent from the current frame, and is shown after the next commit.
4. Write wr_col=6 with data 7'b1111111 and commit → the frame is unchanged and all columns show their prior data.
5. Same-cycle write col 0 = 7'b0000001 and commit → the published frame shows a=0000001 during column 0.
6. Writes without a commit for 3 frames → no swap_ack, and a stays 0 in every dwell.
